param_tdpram: RTL and testbench



---
 rtl/param_tdpram.sv | 144 ++++++++++++++
 tb/tb_param_tdpram.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_tdpram.sv
// True dual-port RAM with a shared clock, optional output register stage,
// per-port read-valid flags, same-address write arbitration and a post-reset clear sweep.
module param_tdpram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int OUT_REG   = 0,
    parameter int COLL_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data_in1,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid1,
    input  logic              en2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] data_in2,
    output logic [DATA_W-1:0] data_out2,
    output logic              valid2,
    output logic              busy,
    output logic              collision
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] r_q1;
    logic [DATA_W-1:0] r_q2;
    logic              r_v1;
    logic              r_v2;
    logic              r_coll;

    logic w_run;
    logic w_rd1;
    logic w_rd2;
    logic w_wr1;
    logic w_wr2;
    logic w_same;

    assign w_run  = (r_state == S_RUN);
    assign w_rd1  = w_run & en1 & ~we1;
    assign w_rd2  = w_run & en2 & ~we2;
    assign w_wr1  = w_run & en1 & we1;
    assign w_wr2  = w_run & en2 & we2;
    assign w_same = w_wr1 & w_wr2 & (addr1 == addr2);

    // Clear sweep visits every word exactly once after reset, then hands over to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + ADDR_W'(1);
            if (r_cnt == {ADDR_W{1'b1}}) begin
                r_state <= S_RUN;
            end
        end
    end

    // The losing port of a same-address double write is suppressed so only the winner lands.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr1 && !(w_same && COLL_MODE == 1)) begin
                r_mem[addr1] <= data_in1;
            end
            if (w_wr2 && !(w_same && COLL_MODE == 0)) begin
                r_mem[addr2] <= data_in2;
            end
        end
    end

    // Reads sample the array before this edge's writes land, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1   <= '0;
            r_q2   <= '0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_v1   <= w_rd1;
            r_v2   <= w_rd2;
            r_coll <= w_same;
            if (w_rd1) begin
                r_q1 <= r_mem[addr1];
            end
            if (w_rd2) begin
                r_q2 <= r_mem[addr2];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_q1b;
            logic [DATA_W-1:0] r_q2b;
            logic              r_v1b;
            logic              r_v2b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q1b <= '0;
                    r_q2b <= '0;
                    r_v1b <= 1'b0;
                    r_v2b <= 1'b0;
                end else begin
                    r_v1b <= r_v1;
                    r_v2b <= r_v2;
                    if (r_v1) begin
                        r_q1b <= r_q1;
                    end
                    if (r_v2) begin
                        r_q2b <= r_q2;
                    end
                end
            end

            assign data_out1 = r_q1b;
            assign data_out2 = r_q2b;
            assign valid1    = r_v1b;
            assign valid2    = r_v2b;
        end else begin : g_direct
            assign data_out1 = r_q1;
            assign data_out2 = r_q2;
            assign valid1    = r_v1;
            assign valid2    = r_v2;
        end
    endgenerate

    assign busy      = ~w_run;
    assign collision = r_coll;

endmodule

// File: tb/tb_param_tdpram.sv
// Drives three param_tdpram variants (latency 1 / A-wins, latency 1 / B-wins,
// latency 2 / A-wins) with shared stimulus and checks them against a behavioural model.
module tb_param_tdpram;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    typedef struct {
        logic       en1;
        logic       we1;
        logic [1:0] a1;
        logic [7:0] d1;
        logic       en2;
        logic       we2;
        logic [1:0] a2;
        logic [7:0] d2;
        logic       expColl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en1 = 1'b0;
    logic       we1 = 1'b0;
    logic       en2 = 1'b0;
    logic       we2 = 1'b0;
    logic [1:0] addr1 = '0;
    logic [1:0] addr2 = '0;
    logic [7:0] data_in1 = '0;
    logic [7:0] data_in2 = '0;

    logic [5:0][7:0] dout;
    logic [5:0]      val;
    logic [2:0]      busyV;
    logic [2:0]      collV;

    exp_t       sb [6][$];
    logic [7:0] mdlA [DEPTH];
    logic [7:0] mdlB [DEPTH];
    logic [7:0] lastData [6];
    int         cycle = 0;
    int         errors = 0;
    int         checks = 0;
    int         modelBusy = DEPTH;
    logic       expColl = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    param_tdpram #(.DATA_W(8), .ADDR_W(2), .OUT_REG(0), .COLL_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .en1(en1), .we1(we1), .addr1(addr1), .data_in1(data_in1),
        .data_out1(dout[0]), .valid1(val[0]),
        .en2(en2), .we2(we2), .addr2(addr2), .data_in2(data_in2),
        .data_out2(dout[1]), .valid2(val[1]),
        .busy(busyV[0]), .collision(collV[0])
    );

    param_tdpram #(.DATA_W(8), .ADDR_W(2), .OUT_REG(0), .COLL_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .en1(en1), .we1(we1), .addr1(addr1), .data_in1(data_in1),
        .data_out1(dout[2]), .valid1(val[2]),
        .en2(en2), .we2(we2), .addr2(addr2), .data_in2(data_in2),
        .data_out2(dout[3]), .valid2(val[3]),
        .busy(busyV[1]), .collision(collV[1])
    );

    param_tdpram #(.DATA_W(8), .ADDR_W(2), .OUT_REG(1), .COLL_MODE(0)) dut2 (
        .clk(clk), .rst(rst),
        .en1(en1), .we1(we1), .addr1(addr1), .data_in1(data_in1),
        .data_out1(dout[4]), .valid1(val[4]),
        .en2(en2), .we2(we2), .addr2(addr2), .data_in2(data_in2),
        .data_out2(dout[5]), .valid2(val[5]),
        .busy(busyV[2]), .collision(collV[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkOutput();
        logic expV;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy dut%0d", i), 32'(busyV[i]), 32'(modelBusy > 0));
            check($sformatf("collision dut%0d", i), 32'(collV[i]), 32'(expColl));
        end
        for (int i = 0; i < 6; i++) begin
            expV = (sb[i].size() > 0) && (sb[i][0].due == cycle);
            check($sformatf("valid dut%0d port%0d", i / 2, i % 2), 32'(val[i]), 32'(expV));
            if (expV) begin
                check($sformatf("rdata dut%0d port%0d", i / 2, i % 2), 32'(dout[i]), 32'(sb[i][0].data));
                lastData[i] = sb[i][0].data;
                void'(sb[i].pop_front());
            end else begin
                check($sformatf("hold dut%0d port%0d", i / 2, i % 2), 32'(dout[i]), 32'(lastData[i]));
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   lat;
        en1      = v.en1;
        we1      = v.we1;
        addr1    = v.a1;
        data_in1 = v.d1;
        en2      = v.en2;
        we2      = v.we2;
        addr2    = v.a2;
        data_in2 = v.d2;
        if (modelBusy == 0) begin
            for (int i = 0; i < 3; i++) begin
                lat = (i == 2) ? 2 : 1;
                e.due = cycle + lat;
                if (v.en1 && !v.we1) begin
                    e.data = (i == 1) ? mdlB[v.a1] : mdlA[v.a1];
                    sb[i * 2].push_back(e);
                end
                if (v.en2 && !v.we2) begin
                    e.data = (i == 1) ? mdlB[v.a2] : mdlA[v.a2];
                    sb[i * 2 + 1].push_back(e);
                end
            end
            if (v.en2 && v.we2) mdlA[v.a2] = v.d2;
            if (v.en1 && v.we1) mdlA[v.a1] = v.d1;
            if (v.en1 && v.we1) mdlB[v.a1] = v.d1;
            if (v.en2 && v.we2) mdlB[v.a2] = v.d2;
        end else begin
            modelBusy--;
        end
        expColl = v.expColl;
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb[i].delete();
            lastData[i] = 8'h00;
        end
        expColl   = 1'b0;
        modelBusy = DEPTH;
        #1;
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
        for (int i = 0; i < DEPTH; i++) begin
            mdlA[i] = 8'h00;
            mdlB[i] = 8'h00;
        end
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic e1, input logic w1, input logic [1:0] a1, input logic [7:0] d1,
                                input logic e2, input logic w2, input logic [1:0] a2, input logic [7:0] d2,
                                input logic ec);
        vec_t v;
        v.en1 = e1; v.we1 = w1; v.a1 = a1; v.d1 = d1;
        v.en2 = e2; v.we2 = w2; v.a2 = a2; v.d2 = d2;
        v.expColl = ec;
        return v;
    endfunction

    task automatic clearAndVerify();
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(mk(1, 1, 2'd1, 8'hA5, 1, 1, 2'd1, 8'h5A, 0));
        end
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(mk(1, 0, 2'(k), 8'h00, 1, 0, 2'(3 - k), 8'h00, 0));
        end
    endtask

    vec_t vecs [16];

    initial begin
        vecs[0]  = mk(1, 1, 2'd0, 8'hAC, 1, 1, 2'd2, 8'hEF, 0);
        vecs[1]  = mk(1, 0, 2'd2, 8'h00, 1, 0, 2'd0, 8'h00, 0);
        vecs[2]  = mk(1, 1, 2'd1, 8'h11, 1, 1, 2'd1, 8'h22, 1);
        vecs[3]  = mk(1, 0, 2'd1, 8'h00, 0, 0, 2'd0, 8'h00, 0);
        vecs[4]  = mk(1, 1, 2'd3, 8'h55, 0, 0, 2'd0, 8'h00, 0);
        vecs[5]  = mk(1, 1, 2'd3, 8'h66, 1, 0, 2'd3, 8'h00, 0);
        vecs[6]  = mk(0, 0, 2'd0, 8'h00, 1, 0, 2'd3, 8'h00, 0);
        vecs[7]  = mk(1, 0, 2'd0, 8'h00, 1, 1, 2'd0, 8'h77, 0);
        vecs[8]  = mk(1, 0, 2'd1, 8'h00, 1, 0, 2'd1, 8'h00, 0);
        vecs[9]  = mk(1, 0, 2'd2, 8'h00, 1, 1, 2'd2, 8'h99, 0);
        vecs[10] = mk(1, 1, 2'd2, 8'h33, 1, 1, 2'd3, 8'h44, 0);
        vecs[11] = mk(1, 0, 2'd2, 8'h00, 1, 0, 2'd3, 8'h00, 0);
        vecs[12] = mk(1, 1, 2'd0, 8'h5A, 0, 0, 2'd0, 8'h00, 0);
        vecs[13] = mk(1, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0);
        vecs[14] = mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0);
        vecs[15] = mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0);

        #2;
        doReset();
        clearAndVerify();

        for (int n = 0; n < 16; n++) begin
            applyStimulus(vecs[n]);
        end

        // A read is left in flight in the latency-2 instance when reset hits.
        applyStimulus(mk(1, 1, 2'd2, 8'hC3, 0, 0, 2'd0, 8'h00, 0));
        applyStimulus(mk(1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00, 0));
        doReset();
        clearAndVerify();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0));
        end

        for (int i = 0; i < 6; i++) begin
            check($sformatf("drained dut%0d port%0d", i / 2, i % 2), 32'(sb[i].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
